// File: rtl/sr_cmd_pkg.sv
// Shared command/state types and helpers for the SR command conditioner.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } state_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // A command is redundant when the flop already holds its target value.
  function automatic logic is_redundant(input cmd_t cmd, input logic q, input logic skip);
    return skip && (((cmd == CMD_SET) && q) || ((cmd == CMD_CLR) && !q));
  endfunction

endpackage

// File: rtl/sr_cmd_conditioner_sync_debounce.sv
// Per-channel synchroniser and debouncer; rise pulses for one cycle when the level goes high.
module sync_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // last of the run of differing samples: flip level, report only upward flips
        cnt_q <= '0;
        level <= synced;
        rise  <= synced;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns raw set/clear requests into arbitrated, spaced, one-cycle s/r pulses for an SR flop.
module sr_cmd_conditioner
  import sr_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned GAP_CYCLES     = 3,
  parameter bit          SET_PRIO       = 1'b1,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic pending,
  output logic conflict,
  output logic drop
);

  localparam int unsigned GW = cnt_width(GAP_CYCLES);

  logic   set_level, set_rise, clr_level, clr_rise;
  logic   set_ev, clr_ev;
  cmd_t   ev_cmd, cand, slot_q, slot_n;
  state_t state_q, state_n;
  logic [GW-1:0] gap_q, gap_n;
  logic   s_n, r_n;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_set_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (set_raw),
    .level(set_level),
    .rise (set_rise)
  );

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_clr_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (clr_raw),
    .level(clr_level),
    .rise (clr_rise)
  );

  assign set_ev   = set_rise & set_level;
  assign clr_ev   = clr_rise & clr_level;
  assign conflict = set_ev & clr_ev;
  assign pending  = (slot_q != CMD_NONE);

  always_comb begin
    if (set_ev && clr_ev) ev_cmd = SET_PRIO ? CMD_SET : CMD_CLR;
    else if (set_ev)      ev_cmd = CMD_SET;
    else if (clr_ev)      ev_cmd = CMD_CLR;
    else                  ev_cmd = CMD_NONE;
  end

  always_comb begin
    state_n = state_q;
    slot_n  = slot_q;
    gap_n   = gap_q;
    s_n     = 1'b0;
    r_n     = 1'b0;
    drop    = 1'b0;
    cand    = CMD_NONE;
    case (state_q)
      ST_IDLE: begin
        // a deferred command goes first; a concurrent event refills the freed slot
        if (slot_q != CMD_NONE) begin
          cand   = slot_q;
          slot_n = ev_cmd;
        end else begin
          cand = ev_cmd;
        end
        if ((cand != CMD_NONE) && !is_redundant(cand, q_fb, SKIP_REDUNDANT)) begin
          state_n = ST_ISSUE;
          s_n     = (cand == CMD_SET);
          r_n     = (cand == CMD_CLR);
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_HOLD;
          gap_n   = GW'(GAP_CYCLES);
        end
      end
      ST_HOLD: begin
        if (gap_q <= GW'(1)) state_n = ST_IDLE;
        else                 gap_n   = gap_q - GW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && (ev_cmd != CMD_NONE)) begin
      slot_n = ev_cmd;
      drop   = (slot_q != CMD_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      slot_q  <= CMD_NONE;
      gap_q   <= '0;
      s       <= 1'b0;
      r       <= 1'b0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      gap_q   <= gap_n;
      s       <= s_n;
      r       <= r_n;
    end
  end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Random and directed stimulus against a history-based reference model with a queued scoreboard.
module tb_sr_cmd_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int GAP  = 3;
  localparam bit PRIO = 1'b1;
  localparam bit SKIP = 1'b1;
  localparam int HMAX = 16384;

  logic clk = 1'b0, rst = 1'b0, set_raw = 1'b0, clr_raw = 1'b0, q_fb = 1'b0;
  logic s, r, pending, conflict, drop;

  always #5 clk = ~clk;

  sr_cmd_conditioner #(
    .SYNC_STAGES   (SYNC),
    .DEB_CYCLES    (DEB),
    .GAP_CYCLES    (GAP),
    .SET_PRIO      (PRIO),
    .SKIP_REDUNDANT(SKIP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_raw (set_raw),
    .clr_raw (clr_raw),
    .q_fb    (q_fb),
    .s       (s),
    .r       (r),
    .pending (pending),
    .conflict(conflict),
    .drop    (drop)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  typedef struct { int cyc; int kind; } pulse_t;
  typedef struct { int cyc; bit conf; bit drp; bit pend; } stat_t;
  pulse_t pulse_q[$];
  stat_t  stat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: raw samples since reset, kinds 1=set 2=clear
  bit raw_hist[2][HMAX];
  int n, m_last, m_slot, ev_prev;
  bit m_lvl[2];

  function automatic bit synced_at(input int ch, input int e);
    int idx = e - SYNC;
    return (idx >= 1) ? raw_hist[ch][idx] : 1'b0;
  endfunction

  function automatic bit redundant(input int kind, input bit q);
    return SKIP && (((kind == 1) && q) || ((kind == 2) && !q));
  endfunction

  always @(posedge clk) begin
    bit rise [2];
    bit all_diff;
    int cand, ev;
    cyc++;
    #1;
    if (!rst) begin
      n = 0; m_last = -1000; m_slot = 0; ev_prev = 0;
      m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
    end else begin
      n++;
      raw_hist[0][n] = set_raw;
      raw_hist[1][n] = clr_raw;
      // issue decisions are only taken once GAP+2 cycles have passed since the last pulse
      if (n - 1 >= m_last + GAP + 1) begin
        cand = (m_slot != 0) ? m_slot : ev_prev;
        if (m_slot != 0) m_slot = ev_prev;
        if (cand != 0 && !redundant(cand, q_fb)) begin
          m_last = n;
          pulse_q.push_back('{cyc, cand});
        end
      end else if (ev_prev != 0) begin
        m_slot = ev_prev;
      end
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (synced_at(ch, n - j) == m_lvl[ch]) all_diff = 1'b0;
        rise[ch] = 1'b0;
        if (all_diff) begin
          m_lvl[ch] = ~m_lvl[ch];
          rise[ch]  = m_lvl[ch];
        end
      end
      if (rise[0] && rise[1]) ev = PRIO ? 1 : 2;
      else if (rise[0])       ev = 1;
      else if (rise[1])       ev = 2;
      else                    ev = 0;
      stat_q.push_back('{cyc, rise[0] && rise[1],
                         (n < m_last + GAP + 1) && (m_slot != 0) && (ev != 0),
                         m_slot != 0});
      ev_prev = ev;
    end
  end

  // Monitor
  always @(negedge clk) begin
    pulse_t p;
    stat_t  st;
    if (rst) begin
      check("s_r_exclusive", 32'(s & r), 0);
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        p = pulse_q.pop_front();
        check("pulse_missing", 0, p.kind);
      end
      if (s || r) begin
        if (pulse_q.size() == 0) begin
          check("pulse_unexpected", s ? 1 : 2, 0);
        end else begin
          p = pulse_q.pop_front();
          check("pulse_cycle", cyc, p.cyc);
          check("pulse_kind", s ? 1 : 2, p.kind);
        end
      end
      if (stat_q.size() > 0) begin
        st = stat_q.pop_front();
        check("stat_cycle", cyc, st.cyc);
        check("conflict", 32'(conflict), 32'(st.conf));
        check("drop", 32'(drop), 32'(st.drp));
        check("pending", 32'(pending), 32'(st.pend));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    pulse_q.delete();
    stat_q.delete();
    #1;
    check("rst_s", 32'(s), 0);
    check("rst_r", 32'(r), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_drop", 32'(drop), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic quiet(input int cycles);
    @(negedge clk);
    set_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int c0, first_s, sc, rc, cnt_s, cnt_r, cnt_c, pend_seen, hs, hc;
    bit did_reset;

    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    check("reset_state_s", 32'(s), 0);
    check("reset_state_pending", 32'(pending), 0);

    // Latency: raw high before edge 1 -> pulse in cycle after edge SYNC+DEB+1
    @(negedge clk);
    set_raw = 1'b1;
    c0 = cyc;
    first_s = -1;
    repeat (12) begin
      @(negedge clk);
      if (s && first_s < 0) first_s = cyc;
    end
    check("set_latency", first_s - c0, SYNC + DEB + 1);
    quiet(12);

    // Bounce shorter than the debounce window
    set_raw = 1'b1;
    cnt_s = 0;
    repeat (3) @(negedge clk);
    set_raw = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (s) cnt_s++;
    end
    check("bounce_no_pulse", cnt_s, 0);

    // Simultaneous rise
    q_fb = PRIO ? 1'b0 : 1'b1;
    set_raw = 1'b1;
    clr_raw = 1'b1;
    cnt_s = 0; cnt_r = 0; cnt_c = 0;
    repeat (14) begin
      @(negedge clk);
      if (s) cnt_s++;
      if (r) cnt_r++;
      if (conflict) cnt_c++;
    end
    check("simul_conflict", cnt_c, 1);
    check("simul_s", cnt_s, PRIO ? 1 : 0);
    check("simul_r", cnt_r, PRIO ? 0 : 1);
    quiet(12);

    // Deferral: clear event lands in the holdoff of a set pulse
    q_fb = 1'b0;
    set_raw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_raw = 1'b1;
    sc = -1; rc = -1; pend_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (pending) pend_seen = 1;
      if (s && sc < 0) begin sc = cyc; q_fb = 1'b1; end
      if (r && rc < 0) rc = cyc;
    end
    check("defer_pending_seen", pend_seen, 1);
    check("defer_spacing", rc - sc, GAP + 2);
    check("defer_pending_cleared", 32'(pending), 0);
    quiet(12);

    // Redundant set while q_fb already high
    q_fb = 1'b1;
    set_raw = 1'b1;
    cnt_s = 0;
    repeat (14) begin
      @(negedge clk);
      if (s) cnt_s++;
    end
    check("redundant_set", cnt_s, SKIP ? 0 : 1);
    quiet(12);

    // Random traffic, one reset while a command is pending
    hs = 0; hc = 0; did_reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hs == 0) begin
        set_raw = ~set_raw;
        hs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 16));
      end else hs--;
      if (hc == 0) begin
        clr_raw = ~clr_raw;
        hc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 16));
      end else hc--;
      if ($urandom_range(0, 39) == 0 && !set_raw && !clr_raw) begin
        set_raw = 1'b1; clr_raw = 1'b1; hs = 10; hc = 10;
      end
      if ($urandom_range(0, 7) == 0) q_fb = ~q_fb;
      if (!did_reset && ((i >= 1000 && pending) || i == 2500)) begin
        did_reset = 1'b1;
        do_reset();
      end
    end
    quiet(40);
    while (pulse_q.size() > 0) begin
      pulse_t p;
      p = pulse_q.pop_front();
      check("pulse_never_seen", 0, p.kind);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
